// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: coefficient width and the subtractor's first-stage record.
package ntt_pkg;

  localparam int COEF_W = 28;

  typedef logic [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t d;
    logic  borrow;
    coef_t q;
    logic  err;
  } sub_s1_t;

endpackage

// File: rtl/mod_sub_core.sv
// Combinational modular-difference correction: adds q back when the raw subtraction borrowed.
// Zero latency, no flow control; shared with the INTT butterfly difference leg.
module mod_sub_core #(
  parameter int W = 28
) (
  input  logic         borrow,
  input  logic [W-1:0] diff,
  input  logic [W-1:0] q,
  output logic [W-1:0] res
);

  // Wraps mod 2^W, which lands in [0, q-1] whenever both operands were in range.
  assign res = borrow ? (diff + q) : diff;

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined (x - y) mod q with operand range flag; 2-cycle latency, one result per cycle.
// Backpressure: in_ready = !v1 | !v2 | out_ready (combinational, no bubbles); stages hold when stalled.
module mod_sub_pipe
  import ntt_pkg::*;
#(
  parameter int DATA_W = COEF_W,
  parameter bit CHK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_err
);

  logic              v1_q, v1_d, v2_q, v2_d;
  logic [DATA_W-1:0] d1_q, d1_d, q1_q, q1_d;
  logic              b1_q, b1_d, e1_q, e1_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              err_q, err_d;
  logic              adv1, adv2;
  logic [DATA_W-1:0] res;

  mod_sub_core #(.W(DATA_W)) u_core (
    .borrow (b1_q),
    .diff   (d1_q),
    .q      (q1_q),
    .res    (res)
  );

  always_comb begin
    adv2  = !v2_q | out_ready;
    adv1  = !v1_q | adv2;
    v1_d  = v1_q;
    d1_d  = d1_q;
    b1_d  = b1_q;
    q1_d  = q1_q;
    e1_d  = e1_q;
    v2_d  = v2_q;
    out_d = out_q;
    err_d = err_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        // MSB of the widened difference is the borrow.
        {b1_d, d1_d} = {1'b0, x} - {1'b0, y};
        q1_d         = q;
        e1_d         = CHK_EN ? ((x >= q) | (y >= q)) : 1'b0;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        out_d = res;
        err_d = e1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      d1_q  <= '0;
      b1_q  <= 1'b0;
      q1_q  <= '0;
      e1_q  <= 1'b0;
      v2_q  <= 1'b0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      d1_q  <= d1_d;
      b1_q  <= b1_d;
      q1_q  <= q1_d;
      e1_q  <= e1_d;
      v2_q  <= v2_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign out       = out_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Scoreboard bench for mod_sub_pipe: directed corner cases, stall/reset scenarios, random traffic.
module tb_mod_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [27:0] x, y, q;
  logic        out_valid, out_ready;
  logic [27:0] out;
  logic        out_err;

  typedef struct {
    logic [27:0] res;
    logic        err;
    int          t;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_sent = 0;
  int          n_rcvd = 0;
  int          cyc = 0;
  bit          hold_vld = 1'b0;
  logic [28:0] hold_dat;
  bit          rnd_done;

  mod_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [27:0] xx, input logic [27:0] yy, input logic [27:0] qq);
    exp_t        e;
    logic [28:0] d;
    e.err = (xx >= qq) || (yy >= qq);
    if (!e.err) begin
      e.res = 28'((longint'(xx) - longint'(yy) + longint'(qq)) % longint'(qq));
    end else begin
      d     = {1'b0, xx} - {1'b0, yy};
      e.res = d[28] ? (d[27:0] + qq) : d[27:0];
    end
    e.t   = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Presents one transaction, waits (bounded) for acceptance, and records its expectation.
  task automatic send(input logic [27:0] xx, input logic [27:0] yy, input logic [27:0] qq, input bit lat);
    exp_t e;
    int   n = 0;
    bit   done = 1'b0;
    x = xx; y = yy; q = qq; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(xx, yy, qq);
        e.t   = cyc;
        e.lat = lat;
        sb.push_back(e);
        n_sent++;
        done = 1'b1;
      end else if (++n > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (hold_vld) check("stall_stable", {3'b0, out_err, out}, {3'b0, hold_dat});
        hold_vld = 1'b1;
        hold_dat = {out_err, out};
      end else begin
        hold_vld = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_rcvd++;
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out", out, e.res);
          check("out_err", out_err, e.err);
          if (e.lat) check("latency", cyc - e.t, 2);
        end
      end
    end
  end

  initial begin
    logic [27:0] rq, rx, ry;
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; q = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic, borrow path, zero, extremes of a large modulus.
    send(28'd10, 28'd3, 28'd17, 1'b1);
    drain();
    send(28'd3, 28'd10, 28'd17, 1'b1);
    send(28'd5, 28'd5, 28'd17, 1'b1);
    send(28'd0, 28'd268369920, 28'd268369921, 1'b1);
    send(28'd268369920, 28'd0, 28'd268369921, 1'b1);
    drain();

    // Out-of-range operand then a clean one.
    send(28'd20, 28'd3, 28'd17, 1'b1);
    send(28'd4, 28'd1, 28'd17, 1'b1);
    drain();

    // Backpressure: both stages fill, input must stall, results 1..4 in order.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(28'(i + 1), 28'd1, 28'd17, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("in_ready_full", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-stream reset discards in-flight data.
    out_ready = 1'b0;
    send(28'd20, 28'd3, 28'd17, 1'b0);
    send(28'd10, 28'd3, 28'd17, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_out_err", out_err, 0);
    sb.delete();
    n_rcvd = 0; n_sent = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(28'd9, 28'd2, 28'd13, 1'b1);
    drain();

    // Random traffic with random downstream stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          rq = 28'($urandom_range(2, 28'hFFFFFFF));
          rx = ($urandom_range(0, 15) == 0) ? 28'($urandom) : 28'($urandom_range(0, int'(rq) - 1));
          ry = ($urandom_range(0, 15) == 0) ? 28'($urandom) : 28'($urandom_range(0, int'(rq) - 1));
          send(rx, ry, rq, 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("count", n_rcvd, n_sent);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
